// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - shared state encoding and width helpers for the FIR sequencer
package fir_ctrl_pkg;

   typedef enum logic [1:0] {
      FLUSH,
      IDLE,
      MAC
   } state_t;

   function automatic int tap_width(input int num_taps);
      return $clog2(num_taps);
   endfunction

   // A single channel still carries a 1-bit channel field so ports never collapse to zero width
   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/fir_ctrl_delay_line.sv
// rtl/fir_ctrl_delay_line.sv - fixed-depth shift register with synchronous active-low clear
module fir_ctrl_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - multi-channel FIR sample/coefficient read sequencer
// Optional coefficient bank select (bank_i) enabled by FIR_CTRL_COEF_BANK_EN.
module fir_seq_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int NUM_TAPS   = 16,
   parameter int NUM_CH     = 2,
   parameter int PIPE_DELAY = 8,
   parameter int ACC_DELAY  = 4,
   localparam int TAP_W     = tap_width(NUM_TAPS),
   localparam int CH_W      = ch_width(NUM_CH),
   localparam int XA_W      = CH_W + TAP_W,
`ifdef FIR_CTRL_COEF_BANK_EN
   localparam int HA_W      = TAP_W + 1
`else
   localparam int HA_W      = TAP_W
`endif
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            s_valid_i,
   output logic            s_ready_o,
   input  logic [CH_W-1:0] s_ch_i,
`ifdef FIR_CTRL_COEF_BANK_EN
   input  logic            bank_i,
`endif
   output logic            x_we_o,
   output logic            x_zero_o,
   output logic [XA_W-1:0] x_waddr_o,
   output logic            x_en_o,
   output logic [XA_W-1:0] x_raddr_o,
   output logic            h_en_o,
   output logic [HA_W-1:0] h_addr_o,
   output logic            fpopmode_bit_o,
   output logic            dv_o,
   output logic [CH_W-1:0] dv_ch_o,
   output logic            busy_o
);

   localparam logic [XA_W-1:0]  FLUSH_LAST = XA_W'(NUM_CH * NUM_TAPS - 1);
   localparam logic [TAP_W-1:0] BEAT_LAST  = TAP_W'(NUM_TAPS - 1);

   state_t           state_q, state_d;
   logic [XA_W-1:0]  flush_cnt_q;
   logic [TAP_W-1:0] beat_q;
   logic [TAP_W-1:0] p_q;
   logic [CH_W-1:0]  ch_q;
   logic [TAP_W-1:0] wptr_q [NUM_CH];
   logic [TAP_W-1:0] rd_tap;
   logic             accept;
   logic             load_flag;
   logic             done_flag;
`ifdef FIR_CTRL_COEF_BANK_EN
   logic             bank_q;
`endif

   assign accept = s_valid_i && (state_q == IDLE);
   // Newest sample sits at p; older taps walk backwards, wrapping inside the channel region
   assign rd_tap = p_q - beat_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= FLUSH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      s_ready_o = 1'b0;
      x_we_o    = 1'b0;
      x_zero_o  = 1'b0;
      x_waddr_o = '0;
      x_en_o    = 1'b0;
      h_en_o    = 1'b0;
      load_flag = 1'b0;
      done_flag = 1'b0;
      unique case (state_q)
         FLUSH: begin
            x_we_o    = 1'b1;
            x_zero_o  = 1'b1;
            x_waddr_o = flush_cnt_q;
            if (flush_cnt_q == FLUSH_LAST) state_d = IDLE;
         end
         IDLE: begin
            s_ready_o = 1'b1;
            x_we_o    = accept;
            x_waddr_o = {s_ch_i, wptr_q[s_ch_i]};
            if (accept) state_d = MAC;
         end
         MAC: begin
            x_en_o    = 1'b1;
            h_en_o    = 1'b1;
            load_flag = (beat_q == '0);
            done_flag = (beat_q == BEAT_LAST);
            if (beat_q == BEAT_LAST) state_d = IDLE;
         end
         default: state_d = FLUSH;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         flush_cnt_q <= '0;
         beat_q      <= '0;
         p_q         <= '0;
         ch_q        <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            wptr_q[i] <= '0;
         end
      end else begin
         if (state_q == FLUSH) flush_cnt_q <= flush_cnt_q + 1'b1;
         if (accept) begin
            ch_q   <= s_ch_i;
            p_q    <= wptr_q[s_ch_i];
            beat_q <= '0;
         end else if (state_q == MAC) begin
            beat_q <= beat_q + 1'b1;
         end
         if (done_flag) wptr_q[ch_q] <= p_q + 1'b1;
      end
   end

`ifdef FIR_CTRL_COEF_BANK_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         bank_q <= 1'b0;
      end else if (accept) begin
         bank_q <= bank_i;
      end
   end
   assign h_addr_o = {bank_q, beat_q};
`else
   assign h_addr_o = beat_q;
`endif

   assign x_raddr_o = {ch_q, rd_tap};
   assign busy_o    = (state_q != IDLE);

   fir_ctrl_delay_line #(
      .WIDTH(1),
      .DEPTH(ACC_DELAY)
   ) u_load_dly (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (load_flag),
      .q_o   (fpopmode_bit_o)
   );

   fir_ctrl_delay_line #(
      .WIDTH(1 + CH_W),
      .DEPTH(PIPE_DELAY)
   ) u_done_dly (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   ({done_flag, ch_q}),
      .q_o   ({dv_o, dv_ch_o})
   );

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - directed self-checking bench for fir_seq_ctrl (4 taps, 2 channels)
module tb_fir_seq_ctrl;

   localparam int NT = 4;
   localparam int NC = 2;
   localparam int PD = 8;
   localparam int AD = 4;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       s_valid_i;
   logic       s_ready_o;
   logic [0:0] s_ch_i;
`ifdef FIR_CTRL_COEF_BANK_EN
   logic       bank_i;
   logic [2:0] h_addr_o;
`else
   logic [1:0] h_addr_o;
`endif
   logic       x_we_o;
   logic       x_zero_o;
   logic [2:0] x_waddr_o;
   logic       x_en_o;
   logic [2:0] x_raddr_o;
   logic       h_en_o;
   logic       fpopmode_bit_o;
   logic       dv_o;
   logic [0:0] dv_ch_o;
   logic       busy_o;

   int total = 0;
   int bad   = 0;
   int n_acc;
   int n_dv;

   always #5 clk_i = ~clk_i;

   fir_seq_ctrl #(
      .NUM_TAPS  (NT),
      .NUM_CH    (NC),
      .PIPE_DELAY(PD),
      .ACC_DELAY (AD)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .s_valid_i     (s_valid_i),
      .s_ready_o     (s_ready_o),
      .s_ch_i        (s_ch_i),
`ifdef FIR_CTRL_COEF_BANK_EN
      .bank_i        (bank_i),
`endif
      .x_we_o        (x_we_o),
      .x_zero_o      (x_zero_o),
      .x_waddr_o     (x_waddr_o),
      .x_en_o        (x_en_o),
      .x_raddr_o     (x_raddr_o),
      .h_en_o        (h_en_o),
      .h_addr_o      (h_addr_o),
      .fpopmode_bit_o(fpopmode_bit_o),
      .dv_o          (dv_o),
      .dv_ch_o       (dv_ch_o),
      .busy_o        (busy_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_flush();
      for (int i = 0; i < NC * NT; i++) begin
         chk("flush_we_zero", {x_we_o, x_zero_o}, 3);
         chk("flush_addr", x_waddr_o, i);
         chk("flush_ready", s_ready_o, 0);
         chk("flush_dv", dv_o, 0);
         tick();
      end
      chk("flush_end_ready", s_ready_o, 1);
      chk("flush_end_busy", busy_o, 0);
   endtask

   // One sample from accept (cycle T) through its result pulse at T+NT+PD
   task automatic run_sample(input int ch, input int p, input int bank);
      s_valid_i = 1'b1;
      s_ch_i    = ch[0];
`ifdef FIR_CTRL_COEF_BANK_EN
      bank_i    = bank[0];
`endif
      #1;
      chk("acc_ready", s_ready_o, 1);
      chk("acc_we", x_we_o, 1);
      chk("acc_zero", x_zero_o, 0);
      chk("acc_waddr", x_waddr_o, ch * NT + p);
      tick();
      s_valid_i = 1'b0;
      s_ch_i    = ~s_ch_i;
`ifdef FIR_CTRL_COEF_BANK_EN
      bank_i    = ~bank_i;
`endif
      for (int k = 0; k < NT; k++) begin
         #1;
         chk("beat_en", {x_en_o, h_en_o}, 3);
         chk("beat_ready", s_ready_o, 0);
         chk("beat_busy", busy_o, 1);
         chk("beat_raddr", x_raddr_o, ch * NT + ((p - k + NT) % NT));
         chk("beat_haddr", h_addr_o, bank * NT + k);
         chk("beat_fpop", fpopmode_bit_o, 0);
         chk("beat_dv", dv_o, 0);
         tick();
      end
      for (int c = NT + 1; c <= NT + PD + 1; c++) begin
         #1;
         chk("post_fpop", fpopmode_bit_o, (c == 1 + AD) ? 1 : 0);
         chk("post_dv", dv_o, (c == NT + PD) ? 1 : 0);
         if (c == NT + PD) chk("post_dv_ch", dv_ch_o, ch);
         if (c == NT + 1) chk("ready_again", s_ready_o, 1);
         tick();
      end
   endtask

   initial begin
      rst_ni    = 1'b0;
      s_valid_i = 1'b0;
      s_ch_i    = 1'b0;
`ifdef FIR_CTRL_COEF_BANK_EN
      bank_i    = 1'b0;
`endif
      tick();
      tick();
      chk("rst_ready", s_ready_o, 0);
      chk("rst_busy", busy_o, 1);
      chk("rst_we_zero", {x_we_o, x_zero_o}, 3);
      chk("rst_waddr", x_waddr_o, 0);
      chk("rst_rd_en", {x_en_o, h_en_o}, 0);
      chk("rst_fpop", fpopmode_bit_o, 0);
      chk("rst_dv", {dv_o, dv_ch_o}, 0);
      rst_ni = 1'b1;
      check_flush();

      run_sample(0, 0, 0);
      run_sample(0, 1, 0);
      run_sample(1, 0, 0);
      run_sample(0, 2, 0);

      // s_valid held: accepts every NT+1 cycles on ch1 starting at wptr 1
      s_valid_i = 1'b1;
      s_ch_i    = 1'b1;
      n_acc     = 0;
      n_dv      = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (s_ready_o && s_valid_i) begin
            chk("b2b_acc_cycle", c, n_acc * (NT + 1));
            chk("b2b_waddr", x_waddr_o, NT + 1 + n_acc);
            n_acc++;
         end
         if (dv_o) begin
            chk("b2b_dv_cycle", c, n_dv * (NT + 1) + NT + PD);
            chk("b2b_dv_ch", dv_ch_o, 1);
            n_dv++;
         end
         tick();
         if (n_acc == 3) s_valid_i = 1'b0;
      end
      chk("b2b_acc_count", n_acc, 3);
      chk("b2b_dv_count", n_dv, 3);

      // Reset on beat 2 of a ch0 sample at wptr 3
      s_valid_i = 1'b1;
      s_ch_i    = 1'b0;
      #1;
      chk("abort_waddr", x_waddr_o, 3);
      tick();
      s_valid_i = 1'b0;
      tick();
      tick();
      chk("abort_beat2_raddr", x_raddr_o, 1);
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      check_flush();
      for (int c = 0; c < 8; c++) begin
         chk("abort_no_dv", dv_o, 0);
         tick();
      end
      run_sample(0, 0, 0);
`ifdef FIR_CTRL_COEF_BANK_EN
      run_sample(0, 1, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
